// File: rtl/bus_responder.sv
// Memory-side responder for the 6502 external bus: mirrored RAM, fixed vectors, RDY wait states.
// Optional IO port and cycle counter at $FFF0/$FFF1 when BUS_RESPONDER_IO_EN is defined.
module bus_responder #(
  parameter int          P_ADDR_BITS = 11,
  parameter int          P_WAIT      = 0,
  parameter logic [15:0] P_NMI_VEC   = 16'h0000,
  parameter logic [15:0] P_RES_VEC   = 16'h0200,
  parameter logic [15:0] P_IRQ_VEC   = 16'h0000
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic [7:0] ABL,
  input  logic [7:0] ABH,
  input  logic       WE,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       RDY,
  output logic [7:0] IO_OUT
);

  typedef enum logic [1:0] {S_START, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdy_q, rdy_d;

  logic [15:0] acc_addr;
  logic        acc_we;
  logic [7:0]  acc_wdata;
  logic        acc_go;
  logic        vec_hit, ext_hit, ram_we;
  logic [7:0]  vec_byte, ext_rd, ram_rd, rd_val;
  logic [P_ADDR_BITS-1:0] ram_idx;

  logic [7:0] mem [0:(1<<P_ADDR_BITS)-1];

  // With no wait states the access completes on the same edge that latches it,
  // so the live bus is used while in S_START and the latches otherwise.
  always_comb begin
    acc_addr  = (state_q == S_START) ? {ABH, ABL} : addr_q;
    acc_we    = (state_q == S_START) ? WE         : we_q;
    acc_wdata = (state_q == S_START) ? WDATA      : wdata_q;
    ram_idx   = acc_addr[P_ADDR_BITS-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    acc_go  = 1'b0;
    case (state_q)
      S_START: begin
        addr_d  = {ABH, ABL};
        we_d    = WE;
        wdata_d = WDATA;
        cnt_d   = P_WAIT[3:0];
        if (P_WAIT == 0) begin
          state_d = S_DONE;
          acc_go  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          acc_go  = 1'b1;
        end
      end
      S_DONE:  state_d = S_START;
      default: state_d = S_START;
    endcase
    rdy_d   = acc_go;
    rdata_d = (acc_go && !acc_we) ? rd_val : rdata_q;
  end

  always_comb begin
    vec_hit = (acc_addr >= 16'hFFFA);
    case (acc_addr[2:0])
      3'd2:    vec_byte = P_NMI_VEC[7:0];
      3'd3:    vec_byte = P_NMI_VEC[15:8];
      3'd4:    vec_byte = P_RES_VEC[7:0];
      3'd5:    vec_byte = P_RES_VEC[15:8];
      3'd6:    vec_byte = P_IRQ_VEC[7:0];
      3'd7:    vec_byte = P_IRQ_VEC[15:8];
      default: vec_byte = 8'h00;
    endcase
    ram_rd = mem[ram_idx];
  end

`ifdef BUS_RESPONDER_IO_EN
  logic [7:0] io_q, io_d;
  logic [7:0] cyc_q, cyc_d;
  logic       io_hit, cyc_hit;

  always_comb begin
    io_hit  = (acc_addr == 16'hFFF0);
    cyc_hit = (acc_addr == 16'hFFF1);
    ext_hit = io_hit || cyc_hit;
    ext_rd  = io_hit ? io_q : cyc_q;
    io_d    = (acc_go && acc_we && io_hit) ? acc_wdata : io_q;
    cyc_d   = cyc_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      io_q  <= 8'h00;
      cyc_q <= 8'h00;
    end else begin
      io_q  <= io_d;
      cyc_q <= cyc_d;
    end
  end

  assign IO_OUT = io_q;
`else
  always_comb begin
    ext_hit = 1'b0;
    ext_rd  = 8'h00;
  end

  assign IO_OUT = 8'h00;
`endif

  // RAM has no reset; a write is suppressed while reset is held so an aborted access never lands.
  always_comb begin
    rd_val = vec_hit ? vec_byte : (ext_hit ? ext_rd : ram_rd);
    ram_we = RES_N && acc_go && acc_we && !vec_hit && !ext_hit;
  end

  always_ff @(posedge CLK) begin
    if (ram_we) mem[ram_idx] <= acc_wdata;
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= S_START;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
    end
  end

  assign RDATA = rdata_q;
  assign RDY   = rdy_q;

endmodule
